// File: rtl/load_store_controller_if.sv
// Avalon-style word bus between the load/store sequencer and memory.
interface load_store_controller_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/load_store_controller.sv
// Memory-stage sequencer for MIPS loads/stores: one word bus access per
// instruction, byte-lane steering for stores and lane merge for loads.
module load_store_controller (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [5:0]              opcode,
    input  logic [31:0]             base,
    input  logic [31:0]             offset,
    input  logic [31:0]             rt_value,
    load_store_controller_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             result
);
    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    logic [5:0]          op_q;
    logic [DATA_W-1:0]   rt_q;
    logic [1:0]          off_q;

    logic [DATA_W-1:0]   ea_c;
    logic [1:0]          o_c;
    logic                legal_c;
    logic                misalign_c;
    logic                store_c;
    logic [3:0]          be_c;
    logic [DATA_W-1:0]   wd_c;

    logic [4:0]          sh_c;
    logic [4:0]          shl_c;
    logic [DATA_W-1:0]   lane_c;
    logic [DATA_W-1:0]   load_c;

    // Decode the incoming request: effective address, legality, lanes, store data.
    always_comb begin
        ea_c       = base + offset;
        o_c        = ea_c[1:0];
        legal_c    = 1'b1;
        misalign_c = 1'b0;
        store_c    = 1'b0;
        be_c       = 4'hF;
        wd_c       = '0;
        case (opcode)
            OP_LB, OP_LBU: be_c = 4'(4'b0001 << o_c);
            OP_LH, OP_LHU: begin
                be_c       = 4'(4'b0011 << o_c);
                misalign_c = o_c[0];
            end
            OP_LW:         misalign_c = |o_c;
            OP_LWL, OP_LWR: begin
                be_c = 4'hF;
            end
            OP_SB: begin
                store_c = 1'b1;
                be_c    = 4'(4'b0001 << o_c);
                wd_c    = {4{rt_value[7:0]}};
            end
            OP_SH: begin
                store_c    = 1'b1;
                be_c       = 4'(4'b0011 << o_c);
                misalign_c = o_c[0];
                wd_c       = {2{rt_value[15:0]}};
            end
            OP_SW: begin
                store_c    = 1'b1;
                misalign_c = |o_c;
                wd_c       = rt_value;
            end
            default:       legal_c = 1'b0;
        endcase
    end

    // Merge the returned word into the load result using the latched byte offset.
    always_comb begin
        sh_c   = {off_q, 3'b000};
        shl_c  = {2'(2'd3 - off_q), 3'b000};
        lane_c = bus.readdata >> sh_c;
        case (op_q)
            OP_LB:   load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            OP_LBU:  load_c = {24'h0, lane_c[7:0]};
            OP_LH:   load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            OP_LHU:  load_c = {16'h0, lane_c[15:0]};
            OP_LWL:  load_c = (bus.readdata << shl_c) | (rt_q & ~(32'hFFFF_FFFF << shl_c));
            OP_LWR:  load_c = (bus.readdata >> sh_c) | (rt_q & ~(32'hFFFF_FFFF >> sh_c));
            default: load_c = bus.readdata;
        endcase
    end

    // Sequencer: issue, hold the bus through waitrequest, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= '0;
            rt_q           <= '0;
            off_q          <= '0;
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.byteenable <= '0;
            bus.writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            result         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        rt_q  <= rt_value;
                        off_q <= o_c;
                        if (!legal_c || misalign_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state          <= ACCESS;
                            busy           <= 1'b1;
                            bus.address    <= {ea_c[31:2], 2'b00};
                            bus.read       <= !store_c;
                            bus.write      <= store_c;
                            bus.byteenable <= be_c;
                            bus.writedata  <= wd_c;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.waitrequest) begin
                        if (bus.read) begin
                            result <= load_c;
                        end
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench for load_store_controller: vector table plus reset/ignored-start sequences.
module tb_load_store_controller;
    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] rt_value;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;

    load_store_controller_if bus ();

    load_store_controller dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .base     (base),
        .offset   (offset),
        .rt_value (rt_value),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] res;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge with the DUT idle; returns at a negedge.
    task automatic run_vec(input int idx, input vec_t v);
        int          done_cyc;
        int          bus_cyc;
        int          exp_lat;
        logic        saw_rd;
        logic        saw_wr;
        logic        stable;
        logic        err_seen;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        string       p;
        p        = $sformatf("v%0d", idx);
        done_cyc = -1;
        bus_cyc  = 0;
        saw_rd   = 1'b0;
        saw_wr   = 1'b0;
        stable   = 1'b1;
        err_seen = 1'b0;
        a        = '0;
        be       = '0;
        wd       = '0;
        start    = 1'b1;
        opcode   = v.op;
        base     = v.base;
        offset   = v.off;
        rt_value = v.rt;
        bus.waitrequest = 1'b1;
        bus.readdata    = v.rdata;
        @(posedge clk);
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== (bus.read | bus.write)) stable = 1'b0;
            if (bus.read || bus.write) begin
                bus_cyc++;
                if (bus.read)  saw_rd = 1'b1;
                if (bus.write) saw_wr = 1'b1;
                if (bus_cyc == 1) begin
                    a  = bus.address;
                    be = bus.byteenable;
                    wd = bus.writedata;
                end else if (a !== bus.address || be !== bus.byteenable || wd !== bus.writedata) begin
                    stable = 1'b0;
                end
            end
            bus.waitrequest = (bus_cyc <= v.waits);
            if (done) begin
                done_cyc = c;
                err_seen = error;
            end
        end
        exp_lat = v.err ? 1 : 2 + v.waits;
        check({p, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check({p, " error"}, 32'(err_seen), 32'(v.err));
        check({p, " bus_cycles"}, 32'(bus_cyc), v.err ? 32'd0 : 32'(v.waits + 1));
        check({p, " bus_stable"}, 32'(stable), 32'd1);
        if (!v.err) begin
            check({p, " read_seen"}, 32'(saw_rd), 32'(!v.op[3]));
            check({p, " write_seen"}, 32'(saw_wr), 32'(v.op[3]));
            check({p, " address"}, a, v.addr);
            check({p, " byteenable"}, 32'(be), 32'(v.be));
            if (v.op[3]) check({p, " writedata"}, wd, v.wd);
        end
        check({p, " result"}, result, v.res);
        @(negedge clk);
        check({p, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bus_cnt;
        int done_cnt;
        int done_at;
        total = 0;
        bad   = 0;
        //           op     base          off           rt            rdata         w  err addr          be     wd            res
        vecs[0]  = '{6'h23, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0,       32'hDEAD_BEEF, 0, 0, 32'h0000_0FFC, 4'hF, 32'h0,       32'hDEAD_BEEF};
        vecs[1]  = '{6'h20, 32'h0000_2000, 32'h3,         32'h0,       32'h8011_2233, 0, 0, 32'h0000_2000, 4'h8, 32'h0,       32'hFFFF_FF80};
        vecs[2]  = '{6'h24, 32'h0000_2000, 32'h3,         32'h0,       32'h8011_2233, 0, 0, 32'h0000_2000, 4'h8, 32'h0,       32'h0000_0080};
        vecs[3]  = '{6'h29, 32'h0000_0100, 32'h2,         32'h0000_ABCD, 32'h0,       3, 0, 32'h0000_0100, 4'hC, 32'hABCD_ABCD, 32'h0000_0080};
        vecs[4]  = '{6'h22, 32'h0000_3000, 32'h1,         32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h0000_3000, 4'hF, 32'h0,     32'hCCDD_3344};
        vecs[5]  = '{6'h26, 32'h0000_3000, 32'h1,         32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h0000_3000, 4'hF, 32'h0,     32'h11AA_BBCC};
        vecs[6]  = '{6'h23, 32'h0000_0000, 32'h6,         32'h0,       32'h0,         0, 1, 32'h0,         4'h0, 32'h0,       32'h11AA_BBCC};
        vecs[7]  = '{6'h3F, 32'h0000_0000, 32'h0,         32'h0,       32'h0,         0, 1, 32'h0,         4'h0, 32'h0,       32'h11AA_BBCC};
        vecs[8]  = '{6'h21, 32'h0000_0010, 32'h2,         32'h0,       32'h8001_7FFF, 1, 0, 32'h0000_0010, 4'hC, 32'h0,       32'hFFFF_8001};
        vecs[9]  = '{6'h25, 32'h0000_0010, 32'h0,         32'h0,       32'h1234_8765, 0, 0, 32'h0000_0010, 4'h3, 32'h0,       32'h0000_8765};
        vecs[10] = '{6'h28, 32'h0000_0040, 32'h1,         32'h1234_56A5, 32'h0,       0, 0, 32'h0000_0040, 4'h2, 32'hA5A5_A5A5, 32'h0000_8765};
        vecs[11] = '{6'h2B, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 32'h0,       2, 0, 32'h0000_0080, 4'hF, 32'hCAFE_F00D, 32'h0000_8765};
        vecs[12] = '{6'h21, 32'h0000_0010, 32'h1,         32'h0,       32'h0,         0, 1, 32'h0,         4'h0, 32'h0,       32'h0000_8765};
        vecs[13] = '{6'h29, 32'h0000_0020, 32'h3,         32'h0,       32'h0,         0, 1, 32'h0,         4'h0, 32'h0,       32'h0000_8765};
        vecs[14] = '{6'h20, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,       32'h7F00_0000, 0, 0, 32'hFFFF_FFFC, 4'h8, 32'h0,       32'h0000_007F};
        vecs[15] = '{6'h22, 32'h0000_0100, 32'h0,         32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h0000_0100, 4'hF, 32'h0,     32'hDD22_3344};
        vecs[16] = '{6'h26, 32'h0000_0100, 32'h3,         32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h0000_0100, 4'hF, 32'h0,     32'h1122_33AA};
        vecs[17] = '{6'h28, 32'h0000_0200, 32'h3,         32'h0000_005A, 32'h0,       0, 0, 32'h0000_0200, 4'h8, 32'h5A5A_5A5A, 32'h1122_33AA};

        reset    = 1'b1;
        start    = 1'b0;
        opcode   = '0;
        base     = '0;
        offset   = '0;
        rt_value = '0;
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        repeat (2) @(negedge clk);
        check("rst read", 32'(bus.read), 32'd0);
        check("rst write", 32'(bus.write), 32'd0);
        check("rst busy_done_error", {29'h0, busy, done, error}, 32'd0);
        check("rst address", bus.address, 32'd0);
        check("rst byteenable_writedata", bus.writedata | 32'(bus.byteenable), 32'd0);
        check("rst result", result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // A start pulse during ACCESS must not queue a second transfer.
        start    = 1'b1;
        opcode   = 6'h23;
        base     = 32'h0000_0500;
        offset   = 32'h0;
        rt_value = 32'h0;
        bus.waitrequest = 1'b1;
        bus.readdata    = 32'h1357_9BDF;
        bus_cnt  = 0;
        done_cnt = 0;
        done_at  = -1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start  = (c == 2);
            opcode = (c == 2) ? 6'h2B : 6'h23;
            if (bus.read || bus.write) bus_cnt++;
            bus.waitrequest = (bus_cnt >= 1 && bus_cnt <= 2);
            if (done) begin
                done_cnt++;
                done_at = c;
            end
        end
        start = 1'b0;
        check("ign bus_cycles", 32'(bus_cnt), 32'd3);
        check("ign done_count", 32'(done_cnt), 32'd1);
        check("ign done_cycle", 32'(done_at), 32'd4);
        check("ign result", result, 32'h1357_9BDF);

        // Reset in the second cycle of a stalled read, with start also asserted.
        start    = 1'b1;
        opcode   = 6'h23;
        base     = 32'h0000_0600;
        offset   = 32'h0;
        bus.waitrequest = 1'b1;
        bus.readdata    = 32'hFEDC_BA98;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rstacc read_c1", 32'(bus.read), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        bus.waitrequest = 1'b0;
        check("rstacc read_after", 32'(bus.read), 32'd0);
        check("rstacc busy_done", {30'h0, busy, done}, 32'd0);
        check("rstacc result", result, 32'd0);
        bus_cnt  = 0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.read || bus.write) bus_cnt++;
            if (done) done_cnt++;
        end
        check("rstacc no_bus", 32'(bus_cnt), 32'd0);
        check("rstacc no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_controller.md
# load_store_controller

Multi-cycle sequencer for all MIPS load/store instructions in the CPU's memory stage. It takes the decoded opcode, base register value, sign-extended immediate and `rt` value, and computes the effective address. It then drives one Avalon-style word access, holding it through `waitrequest`, and returns the byte-merged load result (or commits the store) with a one-cycle `done` pulse. The pipeline control stalls on `busy`.

## Interface
Parameters:
- none; data 32 bits, opcode 6 bits, fixed.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `opcode`  in  6  LB 0x20, LH 0x21, LWL 0x22, LW 0x23, LBU 0x24, LHU 0x25, LWR 0x26, SB 0x28, SH 0x29, SW 0x2B.
- `base`  in  32  `rs` register value.
- `offset`  in  32  sign-extended immediate.
- `rt_value`  in  32  store data, or old `rt` for LWL/LWR merge.
- `address`  out  32  word-aligned bus address (`ea & ~3`).
- `read`  out  1  bus read request.
- `write`  out  1  bus write request.
- `byteenable`  out  4  lane k = bits [8k+7:8k], byte address `address + k` (little-endian).
- `writedata`  out  32  lane-shifted store data.
- `waitrequest`  in  1  slave stall; transfer completes on an edge where `read|write` = 1 and `waitrequest` = 0.
- `readdata`  in  32  valid on the completing edge.
- `busy`  out  1  high while in ACCESS.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `done`: misaligned or illegal opcode.
- `result`  out  32  load value to write back; holds last value until the next `done`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE.** On `start` = 1, latch opcode, `rt_value` and `ea = base + offset` (mod 2^32, no overflow trap).
  - If `opcode` is not in the list above, go to DONE with `error` = 1.
  - If a LH/LHU/SH address has `ea[0]` = 1, go to DONE with `error` = 1.
  - If a LW/SW address has `ea[1:0]` ≠ 0, go to DONE with `error` = 1.
  - No bus cycle is issued in any of these error cases.
  - Otherwise go to ACCESS.
- **ACCESS.** Hold `read` (loads) or `write` (stores), `address`, `byteenable` and `writedata` constant.
  - Stay in ACCESS while `waitrequest` = 1.
  - On the completing edge, capture `readdata`, compute `result`, and go to DONE.
- **DONE.** `done` = 1 for exactly one cycle, then go to IDLE. `start` is accepted again in that following IDLE cycle.
- `byteenable`, with o = `ea[1:0]`:
  - byte ops: `1 << o`
  - halfword ops: `3 << o`
  - word ops, LWL, LWR: `4'hF`
- `writedata`:
  - SB: `rt[7:0]` replicated to all lanes.
  - SH: `rt[15:0]` replicated to both halves.
  - SW: `rt`.
- Load merge, with lane = `readdata >> 8*o`:
  - LB/LBU: sign/zero-extend `lane[7:0]`.
  - LH/LHU: sign/zero-extend `lane[15:0]`.
  - LW: `readdata`.
  - LWL: `(readdata << 8*(3-o)) | (rt & ~(32'hFFFFFFFF << 8*(3-o)))`.
  - LWR: `(readdata >> 8*o) | (rt & ~(32'hFFFFFFFF >> 8*o))`.
- `start` while not in IDLE is ignored and not queued.
- Store `result` is unchanged.

## Timing
- Reset values: state IDLE; `read`, `write`, `busy`, `done`, `error` = 0; `address`, `byteenable`, `writedata`, `result` = 0.
- Start on edge 0, with `waitrequest` = 0 in cycle 1:
  - `read`/`write` and `busy` high in cycle 1.
  - `done` high in cycle 2.
  - Minimum latency: 2 cycles start-to-done.
- Each `waitrequest` cycle adds exactly one cycle.
- Error path: `done` and `error` high in cycle 1, with `read` = `write` = 0 throughout.
- Bus signals change only on edges, never combinationally from `waitrequest`.
- Reset asserted mid-ACCESS: `read`/`write` low on the next edge, no `done`, and the captured data is discarded.
- Reset has priority over `start` on the same edge.

## Test plan
- LW, base 0x1000, offset 0xFFFFFFFC (−4), `readdata` 0xDEADBEEF, no wait:
  - required: `address` 0x0FFC, `byteenable` 0xF, `done` on cycle 2, `result` 0xDEADBEEF.
- LB at ea 0x2003 with `readdata` 0x80112233, then LBU at the same address:
  - required: `byteenable` 0x8; LB `result` 0xFFFFFF80; LBU `result` 0x00000080.
- SH at ea 0x0102, rt 0x0000ABCD, `waitrequest` high 3 cycles:
  - required: `write` held 4 cycles, `byteenable` 0xC, `writedata` 0xABCDABCD, `done` on cycle 5.
- LWL and LWR at ea 0x3001, rt 0x11223344, `readdata` 0xAABBCCDD:
  - required: LWL `result` 0xCCDD3344; LWR `result` 0x11AABBCC.
- LW at ea 0x0006, and opcode 0x3F:
  - required: `done` and `error` in cycle 1; `read` never asserted.
- Reset pulsed in cycle 2 of a stalled read; `start` pulsed mid-ACCESS:
  - required: `read` = 0 on the next edge, no `done`; the ignored `start` issues no second access.
